// File: rtl/config_field_editor.sv
// Configuration field editor: decodes PicoBlaze port writes into mode, cursor and BCD
// field edits for clock, date and timer settings, with calendar-valid day clamping.
module config_field_editor #(
    parameter logic [7:0] CMD_PORT  = 8'h11,
    parameter logic [7:0] LOAD_PORT = 8'h12,
    parameter bit         HOUR_24   = 1'b1,
    parameter int         NFIELDS   = 3,
    parameter int         CW        = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_dato,
    input  logic [7:0]    port_id,
    input  logic          write_strobe,
    input  logic          k_write_strobe,
    output logic [7:0]    btn_data_SS,
    output logic [7:0]    btn_data_MM,
    output logic [7:0]    btn_data_HH,
    output logic [7:0]    btn_data_YEAR,
    output logic [7:0]    btn_data_MES,
    output logic [7:0]    btn_data_DAY,
    output logic [7:0]    btn_data_SS_T,
    output logic [7:0]    btn_data_MM_T,
    output logic [7:0]    btn_data_HH_T,
    output logic          am_pm,
    output logic [CW-1:0] cursor_location,
    output logic [1:0]    config_mode
);

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_CLOCK  = 2'd1;
    localparam logic [1:0] MODE_DATE   = 2'd2;
    localparam logic [1:0] MODE_TIMER  = 2'd3;

    localparam logic [1:0] KEY_RIGHT = 2'b00;
    localparam logic [1:0] KEY_UP    = 2'b01;
    localparam logic [1:0] KEY_DOWN  = 2'b10;
    localparam logic [1:0] KEY_LEFT  = 2'b11;

    localparam int         NUM_FIELDS = 9;
    localparam logic [3:0] F_SS   = 4'd0;
    localparam logic [3:0] F_MM   = 4'd1;
    localparam logic [3:0] F_HH   = 4'd2;
    localparam logic [3:0] F_YEAR = 4'd3;
    localparam logic [3:0] F_MES  = 4'd4;
    localparam logic [3:0] F_DAY  = 4'd5;
    localparam logic [3:0] F_SS_T = 4'd6;
    localparam logic [3:0] F_MM_T = 4'd7;
    localparam logic [3:0] F_HH_T = 4'd8;

    localparam logic [CW-1:0] CUR_LAST = CW'(NFIELDS - 1);
    localparam logic [CW-1:0] CUR_ONE  = CW'(1);

    function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
        return ({4'b0, v[7:4]} * 8'd10) + {4'b0, v[3:0]};
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
        logic [3:0] tens_n;
        logic [3:0] units_n;
        tens_n  = 4'(v / 8'd10);
        units_n = 4'(v % 8'd10);
        return {tens_n, units_n};
    endfunction

    function automatic logic [7:0] month_days(input logic [7:0] mes, input logic [7:0] year);
        logic [1:0] year_lsb;
        year_lsb = 2'(bcd_to_bin(year));
        case (mes)
            8'h02:                      return (year_lsb == 2'b00) ? 8'd29 : 8'd28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'd30;
            default:                    return 8'd31;
        endcase
    endfunction

    function automatic logic [7:0] field_lo(input logic [3:0] f);
        case (f)
            F_MES, F_DAY: return 8'd1;
            F_HH:         return HOUR_24 ? 8'd0 : 8'd1;
            default:      return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] field_hi(input logic [3:0] f, input logic [7:0] maxday);
        case (f)
            F_HH:    return HOUR_24 ? 8'd23 : 8'd12;
            F_YEAR:  return 8'd99;
            F_MES:   return 8'd12;
            F_DAY:   return maxday;
            F_HH_T:  return 8'd23;
            default: return 8'd59;
        endcase
    endfunction

    function automatic logic [7:0] field_reset(input logic [3:0] f);
        case (f)
            F_HH:         return HOUR_24 ? 8'h00 : 8'h12;
            F_MES, F_DAY: return 8'h01;
            default:      return 8'h00;
        endcase
    endfunction

    logic [7:0]    field_q [NUM_FIELDS];
    logic [7:0]    field_d [NUM_FIELDS];
    logic          am_pm_q, am_pm_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic [1:0]    config_mode_q, config_mode_d;
    logic          key_valid_q, key_valid_d;
    logic [1:0]    key_code_q, key_code_d;

    logic       strb, cmd_wr, load_wr;
    logic [3:0] sel;
    logic       edit_ok;
    logic [7:0] cur_maxday, new_maxday;
    logic [7:0] cur_bin, sel_lo, sel_hi, up_val, dn_val, load_bin;
    logic       load_ok;
    logic       hh_toggle_up, hh_toggle_dn;

    assign strb    = write_strobe | k_write_strobe;
    assign cmd_wr  = strb && (port_id == CMD_PORT);
    assign load_wr = strb && (port_id == LOAD_PORT);

    always_comb begin
        case (config_mode_q)
            MODE_CLOCK: sel = F_SS   + 4'(cursor_q);
            MODE_DATE:  sel = F_YEAR + 4'(cursor_q);
            MODE_TIMER: sel = F_SS_T + 4'(cursor_q);
            default:    sel = F_SS;
        endcase
    end

    assign edit_ok    = (config_mode_q != MODE_NORMAL) && (int'(cursor_q) < NFIELDS);
    assign cur_maxday = month_days(field_q[F_MES], field_q[F_YEAR]);
    assign cur_bin    = bcd_to_bin(field_q[sel]);
    assign sel_lo     = field_lo(sel);
    assign sel_hi     = field_hi(sel, cur_maxday);
    assign up_val     = (cur_bin >= sel_hi) ? sel_lo : cur_bin + 8'd1;
    assign dn_val     = (cur_bin <= sel_lo) ? sel_hi : cur_bin - 8'd1;

    // In 12-hour mode am_pm flips only across the 11/12 boundary, never across 12/01.
    assign hh_toggle_up = !HOUR_24 && (sel == F_HH) && (cur_bin == 8'd11);
    assign hh_toggle_dn = !HOUR_24 && (sel == F_HH) && (cur_bin == 8'd12);

    assign load_bin = bcd_to_bin(in_dato);
    assign load_ok  = (in_dato[7:4] <= 4'd9) && (in_dato[3:0] <= 4'd9) &&
                      (load_bin >= sel_lo) && (load_bin <= sel_hi);

    always_comb begin
        // NOTE: every _d starts from its _q, so no branch below can leave a latch behind.
        field_d       = field_q;
        am_pm_d       = am_pm_q;
        cursor_d      = cursor_q;
        config_mode_d = config_mode_q;
        key_valid_d   = 1'b0;
        key_code_d    = key_code_q;
        new_maxday    = 8'd31;

        if (cmd_wr) begin
            config_mode_d = in_dato[4:3];
            key_valid_d   = in_dato[2];
            key_code_d    = in_dato[1:0];
        end

        // A load write swallows any pending key, even when the load value is rejected.
        if (load_wr) begin
            if (edit_ok && load_ok) begin
                field_d[sel] = in_dato;
            end
        end else if (key_valid_q && edit_ok) begin
            case (key_code_q)
                KEY_LEFT:  cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + CUR_ONE;
                KEY_RIGHT: cursor_d = (cursor_q == '0) ? CUR_LAST : cursor_q - CUR_ONE;
                KEY_UP: begin
                    field_d[sel] = bin_to_bcd(up_val);
                    if (hh_toggle_up) am_pm_d = !am_pm_q;
                end
                default: begin
                    field_d[sel] = bin_to_bcd(dn_val);
                    if (hh_toggle_dn) am_pm_d = !am_pm_q;
                end
            endcase
        end

        if (cmd_wr && (in_dato[4:3] != config_mode_q)) begin
            cursor_d = '0;
        end

        new_maxday = month_days(field_d[F_MES], field_d[F_YEAR]);
        if (bcd_to_bin(field_d[F_DAY]) > new_maxday) begin
            field_d[F_DAY] = bin_to_bcd(new_maxday);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so every flop samples pre-edge values, order-independent.
        if (reset) begin
            // NOTE: the field array is only nine registers, so it resets like any flop.
            for (int i = 0; i < NUM_FIELDS; i++) begin
                field_q[i] <= field_reset(4'(i));
            end
            am_pm_q       <= 1'b0;
            cursor_q      <= '0;
            config_mode_q <= MODE_NORMAL;
            key_valid_q   <= 1'b0;
            key_code_q    <= 2'b00;
        end else begin
            field_q       <= field_d;
            am_pm_q       <= am_pm_d;
            cursor_q      <= cursor_d;
            config_mode_q <= config_mode_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
        end
    end

    assign btn_data_SS     = field_q[F_SS];
    assign btn_data_MM     = field_q[F_MM];
    assign btn_data_HH     = field_q[F_HH];
    assign btn_data_YEAR   = field_q[F_YEAR];
    assign btn_data_MES    = field_q[F_MES];
    assign btn_data_DAY    = field_q[F_DAY];
    assign btn_data_SS_T   = field_q[F_SS_T];
    assign btn_data_MM_T   = field_q[F_MM_T];
    assign btn_data_HH_T   = field_q[F_HH_T];
    assign am_pm           = am_pm_q;
    assign cursor_location = cursor_q;
    assign config_mode     = config_mode_q;

endmodule

// File: tb/tb_config_field_editor.sv
// Bench for config_field_editor: a 24-hour and a 12-hour instance share one stimulus
// stream and are compared every cycle against an integer calendar model.
module tb_config_field_editor;

    localparam logic [7:0] CMD  = 8'h11;
    localparam logic [7:0] LOAD = 8'h12;
    localparam int         NF   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_dato = 8'h00;
    logic [7:0] port_id = 8'h00;
    logic       write_strobe = 1'b0;
    logic       k_write_strobe = 1'b0;

    logic [7:0] q [2][9];
    logic       q_ampm [2];
    logic [1:0] q_cur [2];
    logic [1:0] q_mode [2];

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    config_field_editor #(.HOUR_24(1'b1)) dut24 (
        .clk(clk), .reset(reset), .in_dato(in_dato), .port_id(port_id),
        .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
        .btn_data_SS(q[0][0]), .btn_data_MM(q[0][1]), .btn_data_HH(q[0][2]),
        .btn_data_YEAR(q[0][3]), .btn_data_MES(q[0][4]), .btn_data_DAY(q[0][5]),
        .btn_data_SS_T(q[0][6]), .btn_data_MM_T(q[0][7]), .btn_data_HH_T(q[0][8]),
        .am_pm(q_ampm[0]), .cursor_location(q_cur[0]), .config_mode(q_mode[0])
    );

    config_field_editor #(.HOUR_24(1'b0)) dut12 (
        .clk(clk), .reset(reset), .in_dato(in_dato), .port_id(port_id),
        .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
        .btn_data_SS(q[1][0]), .btn_data_MM(q[1][1]), .btn_data_HH(q[1][2]),
        .btn_data_YEAR(q[1][3]), .btn_data_MES(q[1][4]), .btn_data_DAY(q[1][5]),
        .btn_data_SS_T(q[1][6]), .btn_data_MM_T(q[1][7]), .btn_data_HH_T(q[1][8]),
        .am_pm(q_ampm[1]), .cursor_location(q_cur[1]), .config_mode(q_mode[1])
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state in plain integers: field values in binary, index order
    // SS MM HH YEAR MES DAY SS_T MM_T HH_T.
    int mf [2][9];
    int mmode [2];
    int mcur [2];
    int mampm [2];
    int mkv [2];
    int mkc [2];
    string fname [9] = '{"SS", "MM", "HH", "YEAR", "MES", "DAY", "SS_T", "MM_T", "HH_T"};

    function automatic int maxday_of(input int mes, input int year);
        if (mes == 2) return (year % 4 == 0) ? 29 : 28;
        if (mes == 4 || mes == 6 || mes == 9 || mes == 11) return 30;
        return 31;
    endfunction

    function automatic int lo_of(input int idx, input bit h24);
        if (idx == 4 || idx == 5) return 1;
        if (idx == 2 && !h24) return 1;
        return 0;
    endfunction

    function automatic int hi_of(input int idx, input bit h24, input int md);
        case (idx)
            2:       return h24 ? 23 : 12;
            3:       return 99;
            4:       return 12;
            5:       return md;
            8:       return 23;
            default: return 59;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_step(input int i, input bit h24);
        bit cmd, ld;
        int idx, v, lo, hi, span, newmode, md;
        if (reset) begin
            for (int f = 0; f < 9; f++) mf[i][f] = 0;
            mf[i][2] = h24 ? 0 : 12;
            mf[i][4] = 1;
            mf[i][5] = 1;
            mmode[i] = 0; mcur[i] = 0; mampm[i] = 0; mkv[i] = 0; mkc[i] = 0;
            return;
        end
        cmd = (write_strobe || k_write_strobe) && port_id == CMD;
        ld  = (write_strobe || k_write_strobe) && port_id == LOAD;
        newmode = cmd ? int'(in_dato[4:3]) : mmode[i];
        idx = (mmode[i] - 1) * 3 + mcur[i];
        md  = maxday_of(mf[i][4], mf[i][3]);
        if (ld) begin
            if (mmode[i] != 0 && in_dato[7:4] <= 9 && in_dato[3:0] <= 9) begin
                v = int'(in_dato[7:4]) * 10 + int'(in_dato[3:0]);
                if (v >= lo_of(idx, h24) && v <= hi_of(idx, h24, md)) mf[i][idx] = v;
            end
        end else if (mkv[i] != 0 && mmode[i] != 0) begin
            if (mkc[i] == 0) mcur[i] = (mcur[i] + NF - 1) % NF;
            else if (mkc[i] == 3) mcur[i] = (mcur[i] + 1) % NF;
            else begin
                lo = lo_of(idx, h24);
                hi = hi_of(idx, h24, md);
                span = hi - lo + 1;
                v = mf[i][idx];
                if (!h24 && idx == 2 && ((mkc[i] == 1 && v == 11) || (mkc[i] == 2 && v == 12)))
                    mampm[i] = 1 - mampm[i];
                if (mkc[i] == 1) mf[i][idx] = lo + (v - lo + 1) % span;
                else             mf[i][idx] = lo + (v - lo + span - 1) % span;
            end
        end
        if (cmd) begin
            if (newmode != mmode[i]) mcur[i] = 0;
            mmode[i] = newmode;
            mkv[i] = int'(in_dato[2]);
            mkc[i] = int'(in_dato[1:0]);
        end else begin
            mkv[i] = 0;
        end
        md = maxday_of(mf[i][4], mf[i][3]);
        if (mf[i][5] > md) mf[i][5] = md;
    endtask

    always @(posedge clk) begin
        model_step(0, 1'b1);
        model_step(1, 1'b0);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                for (int f = 0; f < 9; f++)
                    check($sformatf("model_%0d_%s", i, fname[f]), q[i][f], to_bcd(mf[i][f]));
                check($sformatf("model_%0d_am_pm", i), 8'(q_ampm[i]), 8'(mampm[i]));
                check($sformatf("model_%0d_cursor", i), 8'(q_cur[i]), 8'(mcur[i]));
                check($sformatf("model_%0d_mode", i), 8'(q_mode[i]), 8'(mmode[i]));
            end
        end
    end

    task automatic wr(input logic [7:0] pid, input logic [7:0] d, input bit use_k = 1'b0);
        port_id = pid;
        in_dato = d;
        write_strobe = !use_k;
        k_write_strobe = use_k;
        @(negedge clk);
        write_strobe = 1'b0;
        k_write_strobe = 1'b0;
    endtask

    task automatic cmd_key(input logic [7:0] d);
        wr(CMD, d);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_ss", q[0][0], 8'h00);
        check("rst_hh24", q[0][2], 8'h00);
        check("rst_hh12", q[1][2], 8'h12);
        check("rst_mes", q[0][4], 8'h01);
        check("rst_day", q[0][5], 8'h01);
        check("rst_mode", 8'(q_mode[0]), 8'h00);
        check("rst_cursor", 8'(q_cur[0]), 8'h00);
        reset = 1'b0;

        cmd_key(8'h05);
        check("mode0_up_ignored", q[0][0], 8'h00);

        wr(CMD, 8'h08);
        for (int k = 1; k <= 60; k++) begin
            cmd_key(8'h0D);
            check("ss_count", q[0][0], to_bcd(k % 60));
        end
        cmd_key(8'h0E);
        check("ss_down_wrap", q[0][0], 8'h59);

        cmd_key(8'h0F); check("left_1", 8'(q_cur[0]), 8'd1);
        cmd_key(8'h0F); check("left_2", 8'(q_cur[0]), 8'd2);
        cmd_key(8'h0F); check("left_wrap", 8'(q_cur[0]), 8'd0);
        cmd_key(8'h0C); check("right_wrap", 8'(q_cur[0]), 8'd2);
        wr(CMD, 8'h10);
        check("mode_change_cursor", 8'(q_cur[0]), 8'd0);

        wr(LOAD, 8'h23); check("load_year", q[0][3], 8'h23);
        cmd_key(8'h17); cmd_key(8'h17);
        wr(LOAD, 8'h31); check("load_day31", q[0][5], 8'h31);
        cmd_key(8'h14);
        wr(LOAD, 8'h02); check("feb_clamp", q[0][5], 8'h28);
        cmd_key(8'h14);
        wr(LOAD, 8'h24);
        cmd_key(8'h14);
        wr(LOAD, 8'h29); check("leap_day29", q[0][5], 8'h29);
        wr(LOAD, 8'h30); check("day30_rejected", q[0][5], 8'h29);
        cmd_key(8'h17);
        wr(LOAD, 8'h25); check("year_clamp", q[0][5], 8'h28);
        cmd_key(8'h17);
        cmd_key(8'h16); cmd_key(8'h16);
        check("mes_down_wrap", q[0][4], 8'h12);

        wr(CMD, 8'h08);
        cmd_key(8'h0F); cmd_key(8'h0F);
        wr(LOAD, 8'h11);
        check("hh12_load", q[1][2], 8'h11);
        check("hh12_am", 8'(q_ampm[1]), 8'd0);
        cmd_key(8'h0D);
        check("hh12_up12", q[1][2], 8'h12);
        check("hh12_pm", 8'(q_ampm[1]), 8'd1);
        cmd_key(8'h0D);
        check("hh12_up01", q[1][2], 8'h01);
        check("hh12_pm_kept", 8'(q_ampm[1]), 8'd1);
        check("hh24_up13", q[0][2], 8'h13);
        wr(LOAD, 8'h13);
        check("hh12_load13_rejected", q[1][2], 8'h01);
        cmd_key(8'h0E);
        check("hh12_down12", q[1][2], 8'h12);
        cmd_key(8'h0E);
        check("hh12_down11", q[1][2], 8'h11);
        check("hh12_am_again", 8'(q_ampm[1]), 8'd0);
        check("hh24_am_pm_zero", 8'(q_ampm[0]), 8'd0);

        cmd_key(8'h0C); cmd_key(8'h0C);
        wr(CMD, 8'h0D, 1'b1);
        wr(LOAD, 8'h42);
        check("load_beats_key", q[0][0], 8'h42);
        wr(LOAD, 8'h5A);
        check("load_5a_rejected", q[0][0], 8'h42);
        wr(CMD, 8'h0F);
        wr(LOAD, 8'h17);
        check("load_beats_left", 8'(q_cur[0]), 8'd0);

        wr(CMD, 8'h18, 1'b1);
        cmd_key(8'h1E);
        check("sst_down_wrap", q[0][6], 8'h59);
        cmd_key(8'h1C);
        cmd_key(8'h1E);
        check("hht_down_wrap", q[1][8], 8'h23);
        cmd_key(8'h1D);
        wr(8'h33, 8'h05);
        check("unused_port", q[0][8], 8'h00);
        wr(CMD, 8'h18);
        check("same_mode_cursor", 8'(q_cur[0]), 8'd2);
        wr(CMD, 8'h00);
        cmd_key(8'h07);
        wr(LOAD, 8'h05);
        check("mode0_left_ignored", 8'(q_cur[0]), 8'd0);

        wr(CMD, 8'h0D);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_ss", q[0][0], 8'h00);
        check("midreset_mode", 8'(q_mode[0]), 8'd0);
        @(negedge clk);
        check("midreset_key_dropped", q[0][0], 8'h00);
        repeat (2) @(negedge clk);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
